vga_idx_port_dec: RTL
=====================

Name: vga_idx_port_dec

Overview:
- Parametrised decoder for VGA-style indexed register ports (index at BASE, data at BASE+1), with mono/colour base selected by misc_b0.
- Adds configurable wait-state ready timing, index auto-increment, a write-protect window and a key-unlocked extension index range.
- Sits between the host I/O bus and the CRT/extension register files; generates index, write strobes/data and c_ready_n for each instance (CR, ER, ...).

Parameters:
- INDEX_W, 6, index register width; index space 0..2^INDEX_W-1.
- NUM_STD, 25, standard registers at index 0..NUM_STD-1.
- EXT_BASE, 32, first extension index; extension range EXT_BASE..2^INDEX_W-1.
- MONO_BASE, 16'h03B4, index port address when misc_b0=0.
- COLOR_BASE, 16'h03D4, index port address when misc_b0=1.
- WAIT_CYC, 1, cycles from strobe rise to c_ready_n low (1..15).
- PROT_LAST, 7, indices 0..PROT_LAST are write-protected when prot_en=1.
- KEY_IDX, 31, index of the unlock key register.
- UNLOCK_KEY, 8'hA5, key value.

Ports:
- h_hclk  in  1  host clock
- h_reset_n  in  1  asynchronous, active-low reset
- h_iord  in  1  I/O read strobe (level, held for the access)
- h_iowr  in  1  I/O write strobe
- h_io_16  in  1  16-bit access
- h_io_8  in  1  8-bit access
- misc_b0  in  1  0 selects MONO_BASE, 1 selects COLOR_BASE
- h_io_addr  in  16  I/O address
- h_io_dbus  in  16  write data
- prot_en  in  1  protect enable (CR11[7] style)
- auto_inc_en  in  1  increment index after each data access
- index  out  INDEX_W  current index
- reg_wr  out  1  one-cycle data write pulse
- wr_data  out  8  data for reg_wr
- reg_rd_en  out  1  read enable for the data register at index
- idx_rd_en  out  1  read enable for the index port
- ext_unlocked  out  1  extension range writable/readable
- prot_viol  out  1  one-cycle pulse on suppressed protected write
- c_ready_n  out  1  active-low access complete

Behaviour:
- Reset values: index=0, reg_wr=0, wr_data=0, ext_unlocked=0, prot_viol=0, c_ready_n=1, FSM=IDLE. Reset mid-access aborts immediately; the host access is not acknowledged.
- Decode: idx_hit = addr==BASE; dat_hit = addr==BASE+1. An index is valid when index<NUM_STD, index==KEY_IDX, or index>=EXT_BASE with ext_unlocked=1.
- Port hit conditions: the index port always hits. The data port hits only for a valid index. With no hit, the block gives no strobes and no ready, and c_ready_n stays 1.
- Strobe start is the rising edge of (h_iord|h_iowr), registered.
- h_iord and h_iowr both high: the write takes priority and all read enables are 0.
- Index write, 8-bit: index <= dbus[INDEX_W-1:0] on the start cycle (T0). Upper bits are ignored.
- Index write, 16-bit: index loads at T0; reg_wr pulses at T1 with wr_data=dbus[15:8], using the new index and subject to validity/protection.
- Data write (dat_hit, 8-bit): reg_wr pulses at T1 with wr_data=dbus[7:0].
- Never more than one reg_wr per access.
- Protection: with prot_en=1 and index<=PROT_LAST, reg_wr is suppressed and prot_viol pulses at T1. The access is still acknowledged.
- Unlock: a write to KEY_IDX sets ext_unlocked=1 if data==UNLOCK_KEY, otherwise clears it; the change takes effect from T2. KEY_IDX writes are never reg_wr-forwarded.
- Reads: idx_rd_en = idx_hit & h_iord. reg_rd_en = dat_hit & valid & h_iord. Both are combinational while the strobe is held.
- Auto-increment: when auto_inc_en=1, each acknowledged data-port access (read or write, including 16-bit index+data) increments index by 1 at access end. It wraps 2^INDEX_W-1 -> 0.
- FSM states:
  - IDLE: on strobe start with a hit, go to WAIT; load counter=WAIT_CYC-1.
  - WAIT: decrement each cycle; at 0 go to RDY.
  - RDY: c_ready_n=0. When the strobe drops, go to END.
  - END: c_ready_n=1, apply auto-increment, go to IDLE.
- Ready timing: c_ready_n falls WAIT_CYC cycles after T0.
- Strobe drop in WAIT: abort to IDLE, no increment, and reg_wr is not issued if not already issued.

Decomposition:
- vga_io_pkg: port address constants (MONO/COLOR base), FSM state enum (IDLE, WAIT, RDY, END), default key.
- Sub-module vga_rdy_timer: wait-state counter plus ready FSM, with inputs start/hit/strobe and outputs c_ready_n/acc_end.

Test Plan:
- misc_b0=1, 16-bit write 3D4 data 16'h5511 -> index=0x11 at T0, reg_wr at T1 with wr_data=0x55, c_ready_n low at T1 (WAIT_CYC=1).
- prot_en=1, 8-bit write 3D5 at index 3 -> no reg_wr, prot_viol pulse, ready asserted. Same write at index 8 -> reg_wr with data.
- Write 0xA5 to KEY_IDX, then read index 0x20 -> reg_rd_en=1. Write 0x00 to KEY_IDX, then access 0x20 -> no hit, c_ready_n stays 1.
- auto_inc_en=1, index=0x3F, data read -> index=0x00 after strobe drop. With misc_b0=0, address 3D5 -> no response.
- WAIT_CYC=4, read held 6 cycles -> c_ready_n low from T4 to strobe drop. Strobe dropped at T2 -> no ready, no increment.
- Assert h_reset_n low during WAIT -> all outputs reset, index=0, ext_unlocked=0.

Source files
------------

// File: rtl/vga_io_pkg.sv
// Shared constants and the ready-FSM state type for the VGA indexed-port decoders.
package vga_io_pkg;

  localparam logic [15:0] MONO_BASE_DEF  = 16'h03B4;
  localparam logic [15:0] COLOR_BASE_DEF = 16'h03D4;
  localparam logic [7:0]  UNLOCK_KEY_DEF = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RDY  = 2'd2,
    ST_END  = 2'd3
  } rdy_state_e;

endpackage

// File: rtl/vga_rdy_timer.sv
// Wait-state counter and ready FSM: acknowledges a hit access WAIT_CYC cycles after it starts.
module vga_rdy_timer
  import vga_io_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic h_hclk,
  input  logic h_reset_n,
  input  logic start,
  input  logic hit,
  input  logic strobe,
  output logic c_ready_n,
  output logic acc_end,
  output logic idle
);

  rdy_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge h_hclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start && hit) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(WAIT_CYC - 1);
        end
      end
      // A strobe that drops before the ready point abandons the access silently.
      ST_WAIT: begin
        if (!strobe)           state_d = ST_IDLE;
        else if (cnt_q == 4'd0) state_d = ST_RDY;
        else                   cnt_d   = cnt_q - 4'd1;
      end
      ST_RDY:  if (!strobe) state_d = ST_END;
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    c_ready_n = (state_q != ST_RDY);
    acc_end   = (state_q == ST_END);
    idle      = (state_q == ST_IDLE);
  end

endmodule

// File: rtl/vga_idx_port_dec.sv
// Index/data port decoder with wait states, auto-increment, write protection and key-unlocked extension range.
module vga_idx_port_dec
  import vga_io_pkg::*;
#(
  parameter int unsigned INDEX_W    = 6,
  parameter int unsigned NUM_STD    = 25,
  parameter int unsigned EXT_BASE   = 32,
  parameter logic [15:0] MONO_BASE  = MONO_BASE_DEF,
  parameter logic [15:0] COLOR_BASE = COLOR_BASE_DEF,
  parameter int unsigned WAIT_CYC   = 1,
  parameter int unsigned PROT_LAST  = 7,
  parameter int unsigned KEY_IDX    = 31,
  parameter logic [7:0]  UNLOCK_KEY = UNLOCK_KEY_DEF
) (
  input  logic               h_hclk,
  input  logic               h_reset_n,
  input  logic               h_iord,
  input  logic               h_iowr,
  input  logic               h_io_16,
  input  logic               h_io_8,
  input  logic               misc_b0,
  input  logic [15:0]        h_io_addr,
  input  logic [15:0]        h_io_dbus,
  input  logic               prot_en,
  input  logic               auto_inc_en,
  output logic [INDEX_W-1:0] index,
  output logic               reg_wr,
  output logic [7:0]         wr_data,
  output logic               reg_rd_en,
  output logic               idx_rd_en,
  output logic               ext_unlocked,
  output logic               prot_viol,
  output logic               c_ready_n
);

  localparam logic [INDEX_W-1:0] KEY_I  = INDEX_W'(KEY_IDX);
  localparam logic [INDEX_W-1:0] PROT_I = INDEX_W'(PROT_LAST);

  function automatic logic idx_valid(input logic [INDEX_W-1:0] i, input logic unl);
    int unsigned iv;
    iv = {{(32-INDEX_W){1'b0}}, i};
    return (iv < NUM_STD) || (iv == KEY_IDX) || ((iv >= EXT_BASE) && unl);
  endfunction

  logic [INDEX_W-1:0] index_q, index_d;
  logic               strb_q, pend_q, pend_d, pend16_q, pend16_d, dacc_q, dacc_d;
  logic               reg_wr_q, reg_wr_d, prot_viol_q, prot_viol_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               key_wr_q, key_wr_d, key_ok_q, key_ok_d, ext_q, ext_d;

  logic        strobe, start, idx_hit, dat_hit, cur_valid, hit, wide, acc_go;
  logic        acc_end, idle;
  logic [15:0] base;
  logic [7:0]  byte_sel;

  always_comb begin
    strobe    = h_iord | h_iowr;
    start     = strobe & ~strb_q;
    base      = misc_b0 ? COLOR_BASE : MONO_BASE;
    idx_hit   = (h_io_addr == base);
    dat_hit   = (h_io_addr == base + 16'd1);
    cur_valid = idx_valid(index_q, ext_q);
    hit       = idx_hit | (dat_hit & cur_valid);
    wide      = h_io_16 & ~h_io_8;
    acc_go    = idle & start & hit;
    byte_sel  = pend16_q ? h_io_dbus[15:8] : h_io_dbus[7:0];
  end

  vga_rdy_timer #(.WAIT_CYC(WAIT_CYC)) u_timer (
    .h_hclk    (h_hclk),
    .h_reset_n (h_reset_n),
    .start     (start),
    .hit       (hit),
    .strobe    (strobe),
    .c_ready_n (c_ready_n),
    .acc_end   (acc_end),
    .idle      (idle)
  );

  always_comb begin
    index_d     = index_q;
    pend_d      = 1'b0;
    pend16_d    = pend16_q;
    dacc_d      = dacc_q;
    reg_wr_d    = 1'b0;
    wr_data_d   = wr_data_q;
    prot_viol_d = 1'b0;
    key_wr_d    = 1'b0;
    key_ok_d    = key_ok_q;
    ext_d       = key_wr_q ? key_ok_q : ext_q;

    // Start cycle: latch the index and arm the one data write this access may carry.
    if (acc_go) begin
      dacc_d = dat_hit | (idx_hit & h_iowr & wide);
      if (h_iowr) begin
        if (idx_hit) begin
          index_d  = h_io_dbus[INDEX_W-1:0];
          pend_d   = wide;
          pend16_d = 1'b1;
        end else begin
          pend_d   = 1'b1;
          pend16_d = 1'b0;
        end
      end
    end

    // Following cycle: the write lands against the (possibly new) index.
    if (pend_q && strobe) begin
      if (index_q == KEY_I) begin
        key_wr_d = 1'b1;
        key_ok_d = (byte_sel == UNLOCK_KEY);
      end else if (idx_valid(index_q, ext_q)) begin
        if (prot_en && (index_q <= PROT_I)) begin
          prot_viol_d = 1'b1;
        end else begin
          reg_wr_d  = 1'b1;
          wr_data_d = byte_sel;
        end
      end
    end

    if (acc_end && dacc_q && auto_inc_en) index_d = index_q + INDEX_W'(1);
  end

  always_ff @(posedge h_hclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      strb_q      <= 1'b0;
      index_q     <= '0;
      pend_q      <= 1'b0;
      pend16_q    <= 1'b0;
      dacc_q      <= 1'b0;
      reg_wr_q    <= 1'b0;
      wr_data_q   <= 8'd0;
      prot_viol_q <= 1'b0;
      key_wr_q    <= 1'b0;
      key_ok_q    <= 1'b0;
      ext_q       <= 1'b0;
    end else begin
      strb_q      <= strobe;
      index_q     <= index_d;
      pend_q      <= pend_d;
      pend16_q    <= pend16_d;
      dacc_q      <= dacc_d;
      reg_wr_q    <= reg_wr_d;
      wr_data_q   <= wr_data_d;
      prot_viol_q <= prot_viol_d;
      key_wr_q    <= key_wr_d;
      key_ok_q    <= key_ok_d;
      ext_q       <= ext_d;
    end
  end

  always_comb begin
    index        = index_q;
    reg_wr       = reg_wr_q;
    wr_data      = wr_data_q;
    prot_viol    = prot_viol_q;
    ext_unlocked = ext_q;
    idx_rd_en    = idx_hit & h_iord & ~h_iowr;
    reg_rd_en    = dat_hit & cur_valid & h_iord & ~h_iowr;
  end

endmodule
